control_seq: RTL and testbench

- Multi-cycle, parametrised successor to the single-cycle combinational control decoder.
- Sequences each instruction through FETCH, DECODE, EXEC and MEM states, and waits on a memory-ready handshake.
- Emits the usual control strobes as registered one-cycle pulses, plus a retired-instruction counter, a halt opcode and a memory-timeout error.
- Sits between instruction memory/IR and the datapath (regfile, ALU, data memory, PC).

---
 rtl/control_seq.sv | 202 ++++++++++++++++++++
 tb/tb_control_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> (MEM) per instruction,
// registered one-cycle control strobes, saturating retire counter, halt and
// sticky memory-timeout error.
module control_seq #(
    parameter int IW          = 9,
    parameter int OPW         = 4,
    parameter int ALUW        = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNTW        = 16
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [IW-1:0]   instruction,
    input  logic            instr_valid,
    input  logic            mem_ready,
    input  logic            branch_taken,
    output logic            ir_load,
    output logic            pc_en,
    output logic            branchFlag,
    output logic            memToRegFlag,
    output logic            memWriteFlag,
    output logic            memReadFlag,
    output logic            regWriteFlag,
    output logic            immtoRegFlag,
    output logic            putFlag,
    output logic [ALUW-1:0] ALUOp,
    output logic            halted,
    output logic            mem_err,
    output logic [CNTW-1:0] retired
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW:0]     TMO_LIM  = (TW+1)'(MEM_TIMEOUT);
    localparam logic [ALUW-1:0] ALU_IDLE = ALUW'(4'b0111);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
    typedef enum logic [3:0] {C_NOP, C_ALU, C_LI, C_LD, C_ST, C_BR, C_JMP, C_HALT, C_PUT} cls_t;

    state_t          state_q, state_d;
    cls_t            cls_q, cls_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [TW:0]     tmo_inc;
    logic [OPW-1:0]  opcode;
    logic            unused_bits;

    logic            ir_load_d, pc_en_d, branch_d, m2r_d, mw_d, mr_d, rw_d, imm_d, put_d;
    logic            halted_d, err_d;
    logic [ALUW-1:0] alu_d;
    logic [CNTW-1:0] retired_d;

    // Only the low four opcode bits select an operation; anything above is don't-care.
    assign opcode      = instruction[OPW:1];
    assign unused_bits = ^instruction[IW-1:OPW+1];
    assign tmo_inc     = {1'b0, tmo_q} + {{TW{1'b0}}, 1'b1};

    function automatic cls_t decode_class(input logic itype, input logic [3:0] op);
        if (itype) return C_PUT;
        case (op)
            4'b0000:                                   return C_LI;
            4'b0001:                                   return C_LD;
            4'b0010:                                   return C_ST;
            4'b0011, 4'b0100, 4'b0101, 4'b0110,
            4'b0111, 4'b1100, 4'b1101:                 return C_ALU;
            4'b1000:                                   return C_JMP;
            4'b1001, 4'b1010, 4'b1011:                 return C_BR;
            4'b1111:                                   return C_HALT;
            default:                                   return C_NOP;
        endcase
    endfunction

    function automatic logic [ALUW-1:0] decode_alu(input logic itype, input logic [3:0] op);
        if (itype) return ALU_IDLE;
        case (op)
            4'b0011: return ALUW'(4'b0101);
            4'b0100: return ALUW'(4'b0110);
            4'b0101: return ALUW'(4'b0001);
            4'b0110: return ALUW'(4'b0010);
            4'b0111: return ALUW'(4'b0000);
            4'b1001: return ALUW'(4'b1010);
            4'b1010: return ALUW'(4'b1000);
            4'b1011: return ALUW'(4'b1001);
            4'b1100: return ALUW'(4'b0011);
            4'b1101: return ALUW'(4'b0100);
            default: return ALU_IDLE;
        endcase
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    // Next-state and next-output logic; memory requests, ALUOp and sticky flags hold by default.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        tmo_d     = tmo_q;
        alu_d     = ALUOp;
        ir_load_d = 1'b0;
        pc_en_d   = 1'b0;
        branch_d  = 1'b0;
        m2r_d     = 1'b0;
        mw_d      = memWriteFlag;
        mr_d      = memReadFlag;
        rw_d      = 1'b0;
        imm_d     = 1'b0;
        put_d     = 1'b0;
        halted_d  = halted;
        err_d     = mem_err;
        retired_d = retired;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_load_d = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d   = decode_class(instruction[0], opcode[3:0]);
                alu_d   = decode_alu(instruction[0], opcode[3:0]);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (cls_q)
                    C_ALU:  begin rw_d = 1'b1; pc_en_d = 1'b1; end
                    C_LI:   begin rw_d = 1'b1; imm_d = 1'b1; pc_en_d = 1'b1; end
                    C_PUT:  begin put_d = 1'b1; pc_en_d = 1'b1; end
                    C_BR:   begin branch_d = branch_taken; pc_en_d = 1'b1; end
                    C_JMP:  begin branch_d = 1'b1; pc_en_d = 1'b1; end
                    C_LD:   begin mr_d = 1'b1; tmo_d = '0; state_d = S_MEM; end
                    C_ST:   begin mw_d = 1'b1; tmo_d = '0; state_d = S_MEM; end
                    C_HALT: begin halted_d = 1'b1; state_d = S_HALT; end
                    default: pc_en_d = 1'b1;
                endcase
            end
            S_MEM: begin
                // A ready arriving on the timeout cycle still completes the access.
                if (mem_ready) begin
                    mr_d    = 1'b0;
                    mw_d    = 1'b0;
                    pc_en_d = 1'b1;
                    if (cls_q == C_LD) begin
                        m2r_d = 1'b1;
                        rw_d  = 1'b1;
                    end
                    state_d = S_FETCH;
                end else if (tmo_inc == TMO_LIM) begin
                    mr_d     = 1'b0;
                    mw_d     = 1'b0;
                    err_d    = 1'b1;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    tmo_d = tmo_inc[TW-1:0];
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
        if (pc_en_d) retired_d = sat_inc(retired);
    end

    // State, decoded-instruction and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= S_FETCH;
            cls_q        <= C_NOP;
            tmo_q        <= '0;
            ir_load      <= 1'b0;
            pc_en        <= 1'b0;
            branchFlag   <= 1'b0;
            memToRegFlag <= 1'b0;
            memWriteFlag <= 1'b0;
            memReadFlag  <= 1'b0;
            regWriteFlag <= 1'b0;
            immtoRegFlag <= 1'b0;
            putFlag      <= 1'b0;
            ALUOp        <= ALU_IDLE;
            halted       <= 1'b0;
            mem_err      <= 1'b0;
            retired      <= '0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            tmo_q        <= tmo_d;
            ir_load      <= ir_load_d;
            pc_en        <= pc_en_d;
            branchFlag   <= branch_d;
            memToRegFlag <= m2r_d;
            memWriteFlag <= mw_d;
            memReadFlag  <= mr_d;
            regWriteFlag <= rw_d;
            immtoRegFlag <= imm_d;
            putFlag      <= put_d;
            ALUOp        <= alu_d;
            halted       <= halted_d;
            mem_err      <= err_d;
            retired      <= retired_d;
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// Testbench for control_seq: instruction-level reference model, randomized traffic.
module tb_control_seq;

    localparam int T = 15;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [8:0] instruction;
    logic       instr_valid, mem_ready, branch_taken;

    logic       ir_load, pc_en, branchFlag, memToRegFlag, memWriteFlag, memReadFlag;
    logic       regWriteFlag, immtoRegFlag, putFlag, halted, mem_err;
    logic [3:0] ALUOp;
    logic [15:0] retired;

    logic       d2_ir_load, d2_pc_en, d2_branchFlag, d2_memToRegFlag, d2_memWriteFlag, d2_memReadFlag;
    logic       d2_regWriteFlag, d2_immtoRegFlag, d2_putFlag, d2_halted, d2_mem_err;
    logic [3:0] d2_ALUOp;
    logic [1:0] d2_retired;

    int vectors = 0;
    int miscompares = 0;
    int model_ret = 0;
    logic [3:0] model_alu = 4'b0111;

    // Observed strobe bits: {ir_load,pc_en,branch,memToReg,memWrite,memRead,regWrite,immtoReg,put,halted,mem_err}
    localparam int B_IR = 10, B_PC = 9, B_BR = 8, B_M2R = 7, B_MW = 6, B_MR = 5;
    localparam int B_RW = 4, B_IMM = 3, B_PUT = 2, B_HLT = 1, B_ERR = 0;
    logic [10:0] obs;
    assign obs = {ir_load, pc_en, branchFlag, memToRegFlag, memWriteFlag, memReadFlag,
                  regWriteFlag, immtoRegFlag, putFlag, halted, mem_err};

    typedef enum int {K_NOP, K_ALU, K_LI, K_LD, K_ST, K_BR, K_JMP, K_HALT, K_PUT} kind_e;

    always #5 Clk = ~Clk;

    control_seq dut (
        .Clk(Clk), .Reset_n(Reset_n), .instruction(instruction), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .ir_load(ir_load), .pc_en(pc_en), .branchFlag(branchFlag), .memToRegFlag(memToRegFlag),
        .memWriteFlag(memWriteFlag), .memReadFlag(memReadFlag), .regWriteFlag(regWriteFlag),
        .immtoRegFlag(immtoRegFlag), .putFlag(putFlag), .ALUOp(ALUOp), .halted(halted),
        .mem_err(mem_err), .retired(retired)
    );

    control_seq #(.CNTW(2)) dut_c2 (
        .Clk(Clk), .Reset_n(Reset_n), .instruction(instruction), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .ir_load(d2_ir_load), .pc_en(d2_pc_en), .branchFlag(d2_branchFlag),
        .memToRegFlag(d2_memToRegFlag), .memWriteFlag(d2_memWriteFlag),
        .memReadFlag(d2_memReadFlag), .regWriteFlag(d2_regWriteFlag),
        .immtoRegFlag(d2_immtoRegFlag), .putFlag(d2_putFlag), .ALUOp(d2_ALUOp),
        .halted(d2_halted), .mem_err(d2_mem_err), .retired(d2_retired)
    );

    function automatic kind_e kind_of(input logic [8:0] ins);
        if (ins[0]) return K_PUT;
        case (ins[4:1])
            4'd0: return K_LI;
            4'd1: return K_LD;
            4'd2: return K_ST;
            4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13: return K_ALU;
            4'd8: return K_JMP;
            4'd9, 4'd10, 4'd11: return K_BR;
            4'd15: return K_HALT;
            default: return K_NOP;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [8:0] ins);
        if (ins[0]) return 4'b0111;
        case (ins[4:1])
            4'd3: return 4'b0101;   4'd4: return 4'b0110;   4'd5: return 4'b0001;
            4'd6: return 4'b0010;   4'd7: return 4'b0000;   4'd9: return 4'b1010;
            4'd10: return 4'b1000;  4'd11: return 4'b1001;  4'd12: return 4'b0011;
            4'd13: return 4'b0100;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issues one instruction from FETCH and checks every cycle up to its retire/halt.
    // k = MEM cycle carrying mem_ready (0 = never); taken = branch_taken in EXEC.
    task automatic run_instr(input string name, input logic [8:0] ins, input int k, input bit taken);
        kind_e kd;
        logic [3:0] ea, exp_alu;
        logic [10:0] exp;
        bit is_mem, tmo;
        int endc, exp2;
        kd = kind_of(ins);
        ea = alu_of(ins);
        is_mem = (kd == K_LD) || (kd == K_ST);
        tmo = is_mem && (k == 0 || k > T);
        endc = !is_mem ? 3 : (tmo ? 3 + T : 3 + k);
        instruction = ins;
        instr_valid = 1'b1;
        mem_ready = 1'($urandom);
        branch_taken = 1'($urandom);
        for (int c = 1; c <= endc; c++) begin
            tick();
            exp = '0;
            if (c == 1) exp[B_IR] = 1'b1;
            if (is_mem && c >= 3 && c < endc) exp[kd == K_LD ? B_MR : B_MW] = 1'b1;
            if (c == endc) begin
                if (tmo) begin
                    exp[B_HLT] = 1'b1;
                    exp[B_ERR] = 1'b1;
                end else begin
                    case (kd)
                        K_ALU:  begin exp[B_PC] = 1; exp[B_RW] = 1; end
                        K_LI:   begin exp[B_PC] = 1; exp[B_RW] = 1; exp[B_IMM] = 1; end
                        K_PUT:  begin exp[B_PC] = 1; exp[B_PUT] = 1; end
                        K_BR:   begin exp[B_PC] = 1; exp[B_BR] = taken; end
                        K_JMP:  begin exp[B_PC] = 1; exp[B_BR] = 1; end
                        K_LD:   begin exp[B_PC] = 1; exp[B_RW] = 1; exp[B_M2R] = 1; end
                        K_ST:   exp[B_PC] = 1;
                        K_HALT: exp[B_HLT] = 1;
                        default: exp[B_PC] = 1;
                    endcase
                end
                if (exp[B_PC] && model_ret < 65535) model_ret++;
            end
            exp_alu = (c == 1) ? model_alu : ea;
            exp2 = (model_ret > 3) ? 3 : model_ret;
            vectors++;
            if (obs !== exp || ALUOp !== exp_alu || retired !== 16'(model_ret) || d2_retired !== 2'(exp2)) begin
                miscompares++;
                $display("FAIL %s cyc%0d: got obs=%b alu=%b ret=%0d ret2=%0d, want obs=%b alu=%b ret=%0d ret2=%0d",
                         name, c, obs, ALUOp, retired, d2_retired, exp, exp_alu, model_ret, exp2);
            end
            if (c >= 2) instruction = 9'($urandom);
            instr_valid  = (c < endc) ? 1'($urandom) : 1'b0;
            mem_ready    = (is_mem && c >= 3) ? (c - 2 == k) : 1'($urandom);
            branch_taken = (c == 2) ? taken : 1'($urandom);
        end
        mem_ready = 1'b0;
        model_alu = ea;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        instr_valid = 1'($urandom);
        mem_ready = 1'($urandom);
        tick();
        vectors++;
        if (obs !== 11'b0 || ALUOp !== 4'b0111 || retired !== 16'd0 || d2_retired !== 2'd0) begin
            miscompares++;
            $display("FAIL reset: got obs=%b alu=%b ret=%0d ret2=%0d, want obs=0 alu=0111 ret=0 ret2=0",
                     obs, ALUOp, retired, d2_retired);
        end
        Reset_n = 1'b1;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        model_ret = 0;
        model_alu = 4'b0111;
    endtask

    task automatic test_fetch_idle();
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instruction = 9'($urandom);
            mem_ready = 1'($urandom);
            branch_taken = 1'($urandom);
            tick();
            vectors++;
            if (obs !== 11'b0 || ALUOp !== model_alu) begin
                miscompares++;
                $display("FAIL fetch_idle: got obs=%b alu=%b, want obs=0 alu=%b", obs, ALUOp, model_alu);
            end
        end
    endtask

    task automatic test_add();
        run_instr("add", 9'b000000110, 0, 1'b0);
    endtask

    task automatic test_store();
        run_instr("st_wait4", 9'b000000100, 5, 1'b0);
        run_instr("st_fast", 9'b000000100, 1, 1'b0);
        run_instr("ld_wait2", 9'b000000010, 3, 1'b0);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", 9'b000010010, 0, 1'b1);
        run_instr("beq_not", 9'b000010010, 0, 1'b0);
        run_instr("jmp", 9'b000010000, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [8:0] ins;
        for (int n = 0; n < 40; n++) begin
            ins = 9'($urandom);
            if (!ins[0] && ins[4:1] == 4'd15) ins[1] = 1'b0;
            run_instr("random", ins, $urandom_range(6, 1), 1'($urandom));
            if ($urandom_range(3, 0) == 0) test_fetch_idle();
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 5; n++) run_instr("nop_sat", 9'b000011100, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_instr("ld_ready_at_limit", 9'b000000010, T, 1'b0);
        run_instr("ld_timeout", 9'b000000010, 0, 1'b0);
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== 11'b00000000011 || retired !== 16'(model_ret)) begin
                miscompares++;
                $display("FAIL timeout_hold: got obs=%b ret=%0d, want obs=00000000011 ret=%0d",
                         obs, retired, model_ret);
            end
        end
    endtask

    task automatic test_halt();
        run_instr("halt", 9'b000011110, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            instruction = 9'($urandom);
            instr_valid = 1'b1;
            tick();
            vectors++;
            if (obs !== 11'b00000000010 || ALUOp !== 4'b0111 || retired !== 16'(model_ret)) begin
                miscompares++;
                $display("FAIL halt_hold: got obs=%b alu=%b ret=%0d, want obs=00000000010 alu=0111 ret=%0d",
                         obs, ALUOp, retired, model_ret);
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        instruction = 9'b000000010;
        instr_valid = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) instr_valid = 1'b0;
        end
        vectors++;
        if (memReadFlag !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_mem_req: got memRead=%b, want 1", memReadFlag);
        end
        test_reset();
        test_add();
    endtask

    initial begin
        Reset_n = 1'b0;
        instruction = '0;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        tick();
        test_reset();
        test_fetch_idle();
        test_add();
        test_store();
        test_branch();
        test_back_to_back();
        test_reset();
        test_saturation();
        test_timeout();
        test_reset();
        test_halt();
        test_reset();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
